// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined add/subtract block: op codes, flag bit
// positions inside the {N, Z, C, V} flag vector, and op decode helpers.
package addsub_pkg;

  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_SUB     = 2'b01;
  localparam logic [1:0] OP_ACC_ADD = 2'b10;
  localparam logic [1:0] OP_ACC_SUB = 2'b11;

  localparam int unsigned FLAG_W = 4;
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Flags of an all-zero result: only Z set
  localparam logic [FLAG_W-1:0] FLAGS_RESET = 4'b0100;

  // Accumulator ops take the accumulator as first operand
  function automatic logic is_acc_op(input logic [1:0] op);
    return (op == OP_ACC_ADD) || (op == OP_ACC_SUB);
  endfunction

  // Subtracting ops invert b and inject a carry-in of 1
  function automatic logic is_sub_op(input logic [1:0] op);
    return (op == OP_SUB) || (op == OP_ACC_SUB);
  endfunction

endpackage

// File: rtl/addsub_core.sv
// Combinational add/subtract core.
// Forms x + b (or x + ~b + 1 when sub=1) in WIDTH+1 bits and derives {N,Z,C,V}.
// Optional macro PIPELINED_ADDSUB_SATURATE_EN clamps overflowing results; C is
// always taken from the unclamped sum, N/Z from the value actually returned.
// Ports:
//   x     in  WIDTH   first operand (a or accumulator)
//   b     in  WIDTH   second operand
//   sub   in  1       1 = subtract
//   res   out WIDTH   result (wrapped or clamped)
//   flags out 4       {N, Z, C, V}
module addsub_core
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0]  x,
  input  logic [WIDTH-1:0]  b,
  input  logic              sub,
  output logic [WIDTH-1:0]  res,
  output logic [FLAG_W-1:0] flags
);

  localparam int unsigned SUM_W = WIDTH + 1;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             ovf;

  // Two's complement add with carry-in for subtraction
  always_comb begin
    b_eff = sub ? ~b : b;
    sum   = {1'b0, x} + {1'b0, b_eff} + SUM_W'(sub);
    // Overflow: operands share a sign that the result does not
    ovf   = (x[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
  end

  // Result selection: wrap, or clamp toward the side the operands pointed
  always_comb begin
`ifdef PIPELINED_ADDSUB_SATURATE_EN
    if (ovf) begin
      res = x[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      res = sum[WIDTH-1:0];
    end
`else
    res = sum[WIDTH-1:0];
`endif
  end

  always_comb begin
    flags         = '0;
    flags[FLAG_N] = res[WIDTH-1];
    flags[FLAG_Z] = (res == '0);
    flags[FLAG_C] = sum[WIDTH];
    flags[FLAG_V] = ovf;
  end

endmodule

// File: rtl/pipelined_addsub.sv
// One-stage pipelined add/subtract unit with accumulator and valid/ready
// handshake on both sides. Results and flags appear one cycle after a transfer
// and hold while the consumer stalls.
// Optional macro: PIPELINED_ADDSUB_SATURATE_EN (saturating results).
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_valid / in_ready   request handshake
//   op, a, b              op code and operands
//   acc_clear             synchronous accumulator clear
//   out_valid / out_ready result handshake
//   result, flags         registered result and {N, Z, C, V}
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              acc_clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic [FLAG_W-1:0] flags
);

  logic [WIDTH-1:0]  acc;
  logic [WIDTH-1:0]  x_sel;
  logic [WIDTH-1:0]  core_res;
  logic [FLAG_W-1:0] core_flags;
  logic              xfer;

  // Accept whenever the result register is empty or being drained this cycle
  assign in_ready = !out_valid || out_ready;
  assign xfer     = in_valid && in_ready;

  // A coincident clear makes the accumulator operand zero for this op
  always_comb begin
    x_sel = a;
    if (is_acc_op(op)) begin
      x_sel = acc_clear ? '0 : acc;
    end
  end

  addsub_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .x     (x_sel),
    .b     (b),
    .sub   (is_sub_op(op)),
    .res   (core_res),
    .flags (core_flags)
  );

  // Output register, valid bit and accumulator
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= FLAGS_RESET;
      acc       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      result    <= core_res;
      flags     <= core_flags;
      acc       <= core_res;
    end else begin
      if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (acc_clear) begin
        acc <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub (WIDTH=16): directed cases plus random traffic,
// scored against an integer-arithmetic reference model through a queue.
module tb_pipelined_addsub;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         acc_clear;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;

  typedef struct packed {
    logic [15:0] res;
    logic [3:0]  flg;
  } exp_t;

  exp_t        q[$];
  logic [15:0] model_acc = '0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .acc_clear (acc_clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on the operand values
  function automatic exp_t model(input logic [1:0] o, input logic [15:0] av,
                                 input logic [15:0] bv, input logic clr,
                                 input logic [15:0] accv);
    longint xu, bu, xs, bs, tru, usum;
    logic   is_acc, is_sub, v;
    exp_t   e;
    is_acc = (o == 2'b10) || (o == 2'b11);
    is_sub = (o == 2'b01) || (o == 2'b11);
    xu = is_acc ? (clr ? 64'sd0 : longint'(accv)) : longint'(av);
    bu = longint'(bv);
    xs = (xu >= 32768) ? xu - 65536 : xu;
    bs = (bu >= 32768) ? bu - 65536 : bu;
    tru  = is_sub ? xs - bs : xs + bs;
    usum = is_sub ? xu + (65535 - bu) + 1 : xu + bu;
    v = (tru > 32767) || (tru < -32768);
`ifdef PIPELINED_ADDSUB_SATURATE_EN
    if (v) e.res = (tru > 0) ? 16'h7FFF : 16'h8000;
    else   e.res = 16'(tru);
`else
    e.res = 16'(tru);
`endif
    e.flg = {e.res[15], (e.res == 16'h0000), (usum > 65535), v};
    return e;
  endfunction

  // Stimulus side: predict each accepted request
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (reset === 1'b0) begin
      if (in_valid && in_ready) begin
        e = model(op, a, b, acc_clear, model_acc);
        q.push_back(e);
        model_acc = e.res;
      end else if (acc_clear) begin
        model_acc = '0;
      end
    end
  end

  // Monitor: compare whatever the DUT presents against the queue head
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_out: got out_valid=1 expected no pending result at %0t", $time);
        end else begin
          chk("result", 32'(result), 32'(q[0].res));
          chk("flags", 32'(flags), 32'(q[0].flg));
          if (out_ready) void'(q.pop_front());
        end
      end else begin
        chk("pending_empty", 32'(q.size()), 32'd0);
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [15:0] av, input logic [15:0] bv,
                       input logic clr, input logic rdy, input logic check_en,
                       input logic [15:0] exp_res, input logic [3:0] exp_flg,
                       input string name);
    int n;
    @(posedge clk);
    #1;
    in_valid = 1'b1; op = o; a = av; b = bv; acc_clear = clr; out_ready = rdy;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk({name, "_accept"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; acc_clear = 1'b0;
    if (check_en) begin
      @(negedge clk);
      chk({name, "_valid"}, 32'(out_valid), 32'd1);
      chk({name, "_res"}, 32'(result), 32'(exp_res));
      chk({name, "_flags"}, 32'(flags), 32'(exp_flg));
    end
  endtask

  function automatic logic [15:0] pick();
    case ($urandom % 6)
      0: return 16'h0000;
      1: return 16'h7FFF;
      2: return 16'h8000;
      3: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; op = 2'b00; a = '0; b = '0;
    acc_clear = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", 32'(flags), 32'h4);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    issue(2'b00, 16'h0003, 16'h0004, 1'b0, 1'b1, 1'b1, 16'h0007, 4'b0000, "add_basic");
    issue(2'b01, 16'h0005, 16'h0005, 1'b0, 1'b1, 1'b1, 16'h0000, 4'b0110, "sub_zero");
`ifdef PIPELINED_ADDSUB_SATURATE_EN
    issue(2'b00, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h7FFF, 4'b0001, "add_ovf");
`else
    issue(2'b00, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h8000, 4'b1001, "add_ovf");
`endif

    // Standalone clear, then accumulate
    @(posedge clk);
    #1;
    acc_clear = 1'b1;
    @(posedge clk);
    #1;
    acc_clear = 1'b0;
    issue(2'b10, 16'hAAAA, 16'h0010, 1'b0, 1'b1, 1'b1, 16'h0010, 4'b0000, "acc1");
    issue(2'b10, 16'hAAAA, 16'h0010, 1'b0, 1'b1, 1'b1, 16'h0020, 4'b0000, "acc2");
    issue(2'b10, 16'hAAAA, 16'h0010, 1'b0, 1'b1, 1'b1, 16'h0030, 4'b0000, "acc3");
    issue(2'b11, 16'hAAAA, 16'h0040, 1'b0, 1'b1, 1'b1, 16'hFFF0, 4'b1000, "acc_sub");
    // Clear coinciding with an accumulate op: operand taken as zero
    issue(2'b10, 16'h1111, 16'h0007, 1'b1, 1'b1, 1'b1, 16'h0007, 4'b0000, "acc_clr_op");

    // Back-pressure for three cycles, then drain and accept together
    issue(2'b00, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b0000, "stall_add");
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_result", 32'(result), 32'h3);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1; in_valid = 1'b1; op = 2'b01; a = 16'h000A; b = 16'h0004;
    @(negedge clk);
    chk("nobubble_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("nobubble_valid", 32'(out_valid), 32'd1);
    chk("nobubble_res", 32'(result), 32'h6);

    // Reset while a result is stalled
    issue(2'b00, 16'h1234, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b0000, "pre_rst");
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_flags", 32'(flags), 32'h4);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    model_acc = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    issue(2'b10, 16'h0000, 16'h0005, 1'b0, 1'b1, 1'b1, 16'h0005, 4'b0000, "acc_after_rst");

    // Random traffic with boundary-heavy operands
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom % 4) != 0;
      op        = 2'($urandom);
      a         = pick();
      b         = pick();
      acc_clear = ($urandom % 10) == 0;
      out_ready = ($urandom % 4) != 0;
    end

    @(posedge clk);
    #1;
    in_valid = 1'b0; acc_clear = 1'b0; out_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", 32'(q.size()), 32'd0);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
